// File: rtl/sram_stage_sequencer.sv
// sram_stage_sequencer: launches up to three pipeline stages in fixed order and grants the shared SRAM port to the active one
module sram_stage_sequencer #(
  parameter int AW = 18,
  parameter int DW = 16,
  parameter int TW = 24,
  parameter logic [TW-1:0] TIMEOUT = 24'd1000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      stage_mask,
  output logic            done,
  output logic            busy,
  output logic            error,
  output logic [1:0]      cur_stage,
  output logic [2:0]      stage_start,
  input  logic [2:0]      stage_done,
  input  logic [3*AW-1:0] s_raddr,
  input  logic [3*AW-1:0] s_waddr,
  input  logic [3*DW-1:0] s_wdata,
  input  logic [2:0]      s_wr_enable,
  output logic [AW-1:0]   raddr,
  output logic [AW-1:0]   waddr,
  output logic [DW-1:0]   wdata,
  output logic            wr_enable
);
  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, GAP, ERR, DONE} state_t;
  state_t state, state_nxt;
  logic [1:0] k, k_nxt, g, gs;
  logic [2:0] mask, mask_nxt, above;
  logic [TW-1:0] cnt, cnt_nxt;
  logic err_nxt, wd_hit, none;
  function automatic logic [1:0] lowest(input logic [2:0] v);
    return v[0] ? 2'd0 : v[1] ? 2'd1 : 2'd2;
  endfunction
  // enabled stages strictly after the current one
  assign above = mask & (3'b110 << k);
  assign wd_hit = (TIMEOUT != '0) && (cnt == TIMEOUT - TW'(1));
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      k     <= '0;
      mask  <= '0;
      cnt   <= '0;
      error <= 1'b0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      mask  <= mask_nxt;
      cnt   <= cnt_nxt;
      error <= err_nxt;
    end
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    mask_nxt  = mask;
    cnt_nxt   = cnt;
    err_nxt   = error;
    case (state)
      IDLE: if (start) begin
        mask_nxt  = stage_mask;
        err_nxt   = 1'b0;
        state_nxt = |stage_mask ? LAUNCH : DONE;
        k_nxt     = |stage_mask ? lowest(stage_mask) : k;
      end
      LAUNCH: begin
        cnt_nxt   = '0;
        state_nxt = RUN;
      end
      RUN: begin
        state_nxt = stage_done[k] ? GAP : wd_hit ? ERR : RUN;
        cnt_nxt   = (stage_done[k] || wd_hit) ? cnt : cnt + 1'b1;
      end
      GAP: begin
        state_nxt = |above ? LAUNCH : DONE;
        k_nxt     = |above ? lowest(above) : k;
      end
      ERR: begin
        err_nxt   = 1'b1;
        state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  assign g           = (state == LAUNCH || state == RUN) ? k : 2'd3;
  assign none        = &g;
  assign gs          = none ? 2'd0 : g;
  assign cur_stage   = g;
  assign done        = state == DONE;
  assign busy        = state != IDLE;
  assign stage_start = (state == LAUNCH) ? 3'b001 << k : 3'b000;
  assign raddr       = none ? '0 : s_raddr[gs*AW +: AW];
  assign waddr       = none ? '0 : s_waddr[gs*AW +: AW];
  assign wdata       = none ? '0 : s_wdata[gs*DW +: DW];
  assign wr_enable   = !none && s_wr_enable[gs];
endmodule

// File: tb/tb_sram_stage_sequencer.sv
// tb_sram_stage_sequencer: scoreboard bench; expected per-cycle output vectors are queued from the timing rules, then popped each cycle
module tb_sram_stage_sequencer;
  localparam int AW = 18;
  localparam int DW = 16;
  localparam int TW = 24;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [2:0] stage_mask = '0, stage_done = '0, s_wr_enable = '0, stage_start;
  logic done, busy, error, wr_enable;
  logic [1:0] cur_stage;
  logic [3*AW-1:0] s_raddr, s_waddr;
  logic [3*DW-1:0] s_wdata;
  logic [AW-1:0] raddr, waddr;
  logic [DW-1:0] wdata;
  logic [AW-1:0] ra_k [3] = '{18'h0f0f0, 18'h15555, 18'h2aaaa};
  logic [AW-1:0] wa_k [3] = '{18'h00123, 18'h10456, 18'h3f789};
  logic [DW-1:0] wd_k [3] = '{16'hbeef, 16'h1234, 16'hc0de};
  typedef struct packed {
    logic [2:0]    ss;
    logic          dn, bz, er;
    logic [1:0]    cs;
    logic [AW-1:0] ra, wa;
    logic [DW-1:0] wd;
    logic          we;
  } vec_t;
  vec_t q[$];
  int errors = 0, checks = 0, cyc = 0, restart_at = -1;
  int dly[3], due[3];

  sram_stage_sequencer #(.AW(AW), .DW(DW), .TW(TW), .TIMEOUT(24'd16)) dut (
    .clk(clk), .reset(reset), .start(start), .stage_mask(stage_mask),
    .done(done), .busy(busy), .error(error), .cur_stage(cur_stage),
    .stage_start(stage_start), .stage_done(stage_done),
    .s_raddr(s_raddr), .s_waddr(s_waddr), .s_wdata(s_wdata), .s_wr_enable(s_wr_enable),
    .raddr(raddr), .waddr(waddr), .wdata(wdata), .wr_enable(wr_enable)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [2:0] ss, input logic dn, input logic bz,
                              input logic er, input logic [1:0] cs);
    vec_t v;
    v.ss = ss; v.dn = dn; v.bz = bz; v.er = er; v.cs = cs;
    v.ra = (cs == 2'd3) ? '0 : ra_k[cs];
    v.wa = (cs == 2'd3) ? '0 : wa_k[cs];
    v.wd = (cs == 2'd3) ? '0 : wd_k[cs];
    v.we = (cs == 2'd3) ? 1'b0 : s_wr_enable[cs];
    return v;
  endfunction

  function automatic vec_t sample();
    return vec_t'({stage_start, done, busy, error, cur_stage, raddr, waddr, wdata, wr_enable});
  endfunction

  task automatic push(input int n, input logic [2:0] ss, input logic dn, input logic bz,
                      input logic er, input logic [1:0] cs);
    repeat (n) q.push_back(mk(ss, dn, bz, er, cs));
  endtask

  // each stage answers 11 cycles after its start pulse: launches on 1, 14, 27, done on 40
  task automatic exp_full();
    push(1, 3'b001, 0, 1, 0, 0); push(11, 3'b000, 0, 1, 0, 0); push(1, 3'b000, 0, 1, 0, 3);
    push(1, 3'b010, 0, 1, 0, 1); push(11, 3'b000, 0, 1, 0, 1); push(1, 3'b000, 0, 1, 0, 3);
    push(1, 3'b100, 0, 1, 0, 2); push(11, 3'b000, 0, 1, 0, 2); push(1, 3'b000, 0, 1, 0, 3);
    push(1, 3'b000, 1, 1, 0, 3); push(1, 3'b000, 0, 0, 0, 3);
  endtask

  task automatic begin_seq(input logic [2:0] m, input int d0, input int d1, input int d2, input int ra);
    stage_mask = m; start = 1'b1; restart_at = ra;
    dly = '{d0, d1, d2}; due = '{-1, -1, -1}; stage_done = '0;
    @(posedge clk);
    #1 start = 1'b0; stage_mask = ~m; cyc = 0;
  endtask

  // advance to the middle of the next cycle and play the three stage modules
  task automatic step();
    @(negedge clk);
    cyc++;
    start = (cyc == restart_at);
    for (int i = 0; i < 3; i++) begin
      if (stage_start[i] && dly[i] > 0) due[i] = cyc + dly[i];
      stage_done[i] = (due[i] == cyc);
    end
  endtask

  task automatic test_reset();
    vec_t got, want;
    @(negedge clk);
    got = sample(); want = mk(0, 0, 0, 0, 3); checks++;
    if (got !== want) begin errors++; $display("FAIL reset_hold got=%h want=%h", got, want); end
    reset = 1'b0;
    @(negedge clk);
    got = sample(); checks++;
    if (got !== want) begin errors++; $display("FAIL reset_idle got=%h want=%h", got, want); end
  endtask

  task automatic test_full();
    vec_t got, want;
    s_wr_enable = 3'b111;
    exp_full();
    begin_seq(3'b111, 11, 11, 11, 5);
    while (q.size() > 0) begin
      step(); want = q.pop_front(); got = sample(); checks++;
      if (got !== want) begin errors++; $display("FAIL full c%0d got=%h want=%h", cyc, got, want); end
    end
  endtask

  task automatic test_back_to_back();
    vec_t got, want;
    exp_full();
    begin_seq(3'b111, 11, 11, 11, -1);
    while (q.size() > 0) begin
      step(); want = q.pop_front(); got = sample(); checks++;
      if (got !== want) begin errors++; $display("FAIL b2b c%0d got=%h want=%h", cyc, got, want); end
    end
  endtask

  task automatic test_skip();
    vec_t got, want;
    s_wr_enable = 3'b010;
    push(1, 3'b001, 0, 1, 0, 0); push(11, 3'b000, 0, 1, 0, 0); push(1, 3'b000, 0, 1, 0, 3);
    push(1, 3'b100, 0, 1, 0, 2); push(11, 3'b000, 0, 1, 0, 2); push(1, 3'b000, 0, 1, 0, 3);
    push(1, 3'b000, 1, 1, 0, 3); push(1, 3'b000, 0, 0, 0, 3);
    begin_seq(3'b101, 11, 11, 11, -1);
    while (q.size() > 0) begin
      step(); want = q.pop_front(); got = sample(); checks++;
      if (got !== want) begin errors++; $display("FAIL skip c%0d got=%h want=%h", cyc, got, want); end
    end
    s_wr_enable = 3'b111;
  endtask

  task automatic test_empty();
    vec_t got, want;
    push(1, 3'b000, 1, 1, 0, 3); push(1, 3'b000, 0, 0, 0, 3);
    begin_seq(3'b000, 11, 11, 11, -1);
    while (q.size() > 0) begin
      step(); want = q.pop_front(); got = sample(); checks++;
      if (got !== want) begin errors++; $display("FAIL empty c%0d got=%h want=%h", cyc, got, want); end
    end
  endtask

  // stage 1 hangs: 16 RUN cycles (15..30), ERR on 31, done with error on 32
  task automatic test_watchdog();
    vec_t got, want;
    push(1, 3'b001, 0, 1, 0, 0); push(11, 3'b000, 0, 1, 0, 0); push(1, 3'b000, 0, 1, 0, 3);
    push(1, 3'b010, 0, 1, 0, 1); push(16, 3'b000, 0, 1, 0, 1); push(1, 3'b000, 0, 1, 0, 3);
    push(1, 3'b000, 1, 1, 1, 3); push(2, 3'b000, 0, 0, 1, 3);
    begin_seq(3'b111, 11, 0, 11, -1);
    while (q.size() > 0) begin
      step(); want = q.pop_front(); got = sample(); checks++;
      if (got !== want) begin errors++; $display("FAIL watchdog c%0d got=%h want=%h", cyc, got, want); end
    end
  endtask

  // done arrives on the 16th RUN cycle (count == TIMEOUT-1); the accepted start also clears the old error
  task automatic test_watchdog_edge();
    vec_t got, want;
    push(1, 3'b001, 0, 1, 0, 0); push(16, 3'b000, 0, 1, 0, 0); push(1, 3'b000, 0, 1, 0, 3);
    push(1, 3'b000, 1, 1, 0, 3); push(1, 3'b000, 0, 0, 0, 3);
    begin_seq(3'b001, 16, 0, 0, -1);
    while (q.size() > 0) begin
      step(); want = q.pop_front(); got = sample(); checks++;
      if (got !== want) begin errors++; $display("FAIL wd_edge c%0d got=%h want=%h", cyc, got, want); end
    end
  endtask

  task automatic test_reset_mid();
    vec_t got, want;
    exp_full();
    begin_seq(3'b111, 11, 11, 11, -1);
    while (cyc < 20) begin
      step(); want = q.pop_front(); got = sample(); checks++;
      if (got !== want) begin errors++; $display("FAIL pre_reset c%0d got=%h want=%h", cyc, got, want); end
    end
    q.delete();
    #2 reset = 1'b1;
    #1 got = sample(); want = mk(0, 0, 0, 0, 3); checks++;
    if (got !== want) begin errors++; $display("FAIL async_reset got=%h want=%h", got, want); end
    @(negedge clk);
    reset = 1'b0; stage_done = '0;
    exp_full();
    begin_seq(3'b111, 11, 11, 11, -1);
    while (q.size() > 0) begin
      step(); want = q.pop_front(); got = sample(); checks++;
      if (got !== want) begin errors++; $display("FAIL post_reset c%0d got=%h want=%h", cyc, got, want); end
    end
  endtask

  initial begin
    s_raddr = {ra_k[2], ra_k[1], ra_k[0]};
    s_waddr = {wa_k[2], wa_k[1], wa_k[0]};
    s_wdata = {wd_k[2], wd_k[1], wd_k[0]};
    test_reset();
    test_full();
    test_back_to_back();
    test_skip();
    test_empty();
    test_watchdog();
    test_watchdog_edge();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
